// File: rtl/noc_in_arbiter.sv
// noc_in_arbiter: round-robin req/ack input arbiter with packet lock; NOC_ARB_LOCAL_PRIO_EN gives the local port priority
module noc_in_arbiter #(
  parameter int DATA_WIDTH = 37,
  parameter int NUM_CH     = 5,
  parameter int TAIL_BIT   = 4,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            req_in,
  output logic [NUM_CH-1:0]            ack_out,
  input  logic                         fifo_full,
  output logic [DATA_WIDTH-1:0]        fifo_data,
  output logic [CH_W-1:0]              fifo_src,
  output logic                         fifo_wrreq
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);
  state_t state_q, state_d;
  logic [CH_W-1:0] cur_q, cur_d, ptr_q, ptr_d, src_q, src_d, g, idx;
  logic locked_q, locked_d, wr_q, wr_d, found, keep_ptr;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_split
    assign ch_data[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
  end
`ifdef NOC_ARB_LOCAL_PRIO_EN
  assign keep_ptr = (g == LAST);
`else
  assign keep_ptr = 1'b0;
`endif
  // A locked packet pins the grant to cur even while its requester is idle
  always_comb begin
    found = 1'b0;
    g = ptr_q;
    idx = ptr_q;
    if (locked_q) begin
      found = req_in[cur_q];
      g = cur_q;
    end else begin
`ifdef NOC_ARB_LOCAL_PRIO_EN
      if (req_in[NUM_CH-1]) begin
        found = 1'b1;
        g = LAST;
      end
`endif
      for (int k = 0; k < NUM_CH; k++) begin
        idx = CH_W'((int'(ptr_q) + k) % NUM_CH);
        if (!found && req_in[idx]) begin
          found = 1'b1;
          g = idx;
        end
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    ptr_d = ptr_q;
    locked_d = locked_q;
    ack_d = ack_q;
    data_d = data_q;
    src_d = src_q;
    wr_d = 1'b0;
    if (state_q == IDLE) begin
      if (found && !fifo_full) begin
        state_d = HOLD;
        cur_d = g;
        src_d = g;
        data_d = ch_data[g];
        wr_d = 1'b1;
        ack_d = NUM_CH'(1) << g;
        locked_d = !ch_data[g][TAIL_BIT];
        if (ch_data[g][TAIL_BIT] && !keep_ptr) ptr_d = (g == LAST) ? '0 : g + 1'b1;
      end
    end else if (!req_in[cur_q]) begin
      ack_d = '0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q <= '0;
      ptr_q <= '0;
      locked_q <= 1'b0;
      ack_q <= '0;
      data_q <= '0;
      src_q <= '0;
      wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      ptr_q <= ptr_d;
      locked_q <= locked_d;
      ack_q <= ack_d;
      data_q <= data_d;
      src_q <= src_d;
      wr_q <= wr_d;
    end
  end
  assign ack_out = ack_q;
  assign fifo_data = data_q;
  assign fifo_src = src_q;
  assign fifo_wrreq = wr_q;
endmodule

// File: tb/tb_noc_in_arbiter.sv
// tb_noc_in_arbiter: directed bench for noc_in_arbiter with a 4-phase requester model and write log
module tb_noc_in_arbiter;
  localparam int W = 37;
  localparam int N = 5;
  logic clk = 1'b0, reset = 1'b1, fifo_full = 1'b0, fifo_wrreq;
  logic [N*W-1:0] din = '0;
  logic [N-1:0] req = '0, ack_out;
  logic [W-1:0] fifo_data;
  logic [2:0] fifo_src;
  int checks = 0, errors = 0, nlog = 0;
  bit auto = 1'b0;
  logic [W-1:0] fl [N][8];
  int nf [N], pos [N];
  int lsrc [16];
  logic [W-1:0] ldat [16];
  noc_in_arbiter #(.DATA_WIDTH(W), .NUM_CH(N), .TAIL_BIT(4)) dut (
    .clk(clk), .reset(reset), .data_in(din), .req_in(req), .ack_out(ack_out),
    .fifo_full(fifo_full), .fifo_data(fifo_data), .fifo_src(fifo_src), .fifo_wrreq(fifo_wrreq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Requesters raise req when ack is low and drop it once ack is seen
  task automatic step();
    tick();
    if (fifo_wrreq && nlog < 16) begin
      lsrc[nlog] = int'(fifo_src);
      ldat[nlog] = fifo_data;
      nlog++;
    end
    if (auto)
      for (int c = 0; c < N; c++)
        if (ack_out[c] && req[c]) begin
          req[c] = 1'b0;
          pos[c]++;
        end else if (!ack_out[c] && !req[c] && pos[c] < nf[c]) begin
          req[c] = 1'b1;
          din[c*W +: W] = fl[c][pos[c]];
        end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    fifo_full = 1'b0;
    auto = 1'b0;
    nlog = 0;
    for (int c = 0; c < N; c++) begin
      nf[c] = 0;
      pos[c] = 0;
    end
    tick();
    tick();
    reset = 1'b0;
  endtask
  initial begin
    do_reset();
    check("rst_ack", ack_out, 0);
    check("rst_wr", fifo_wrreq, 0);
    check("rst_data", fifo_data, 0);
    check("rst_src", fifo_src, 0);
    din[0 +: W] = 37'h10;
    req = 5'b00001;
    tick();
    check("single_wr", fifo_wrreq, 1);
    check("single_data", fifo_data, 37'h10);
    check("single_src", fifo_src, 0);
    check("single_ack", ack_out, 5'b00001);
    tick();
    check("single_wr_pulse", fifo_wrreq, 0);
    check("single_ack_hold", ack_out, 5'b00001);
    req = '0;
    tick();
    check("single_ack_drop", ack_out, 0);
    auto = 1'b1;
    fl[0][0] = 37'h10;
    fl[1][0] = 37'h11;
    nf[0] = 1;
    nf[1] = 1;
    run(12);
    check("ptr1_n", nlog, 2);
    check("ptr1_first", lsrc[0], 1);
    check("ptr1_second", lsrc[1], 0);
    do_reset();
    auto = 1'b1;
    for (int c = 0; c < N; c++) begin
      nf[c] = 2;
      for (int k = 0; k < 2; k++) fl[c][k] = 37'h10 | (37'(c) << 8) | (37'(k) << 12);
    end
    run(40);
    check("rr_n", nlog, 10);
    for (int i = 0; i < 6; i++) check($sformatf("rr_src%0d", i), lsrc[i], i % N);
    check("rr_data5", ldat[5], 37'h1010);
    do_reset();
    auto = 1'b1;
    fl[2][0] = 37'h0;
    fl[2][1] = 37'h0;
    fl[2][2] = 37'h10;
    nf[2] = 3;
    run(2);
    fl[0][0] = 37'h10;
    fl[3][0] = 37'h13;
    nf[0] = 1;
    nf[3] = 1;
    run(25);
    check("lock_n", nlog, 5);
    check("lock_s0", lsrc[0], 2);
    check("lock_s1", lsrc[1], 2);
    check("lock_s2", lsrc[2], 2);
    check("lock_tail", ldat[2], 37'h10);
    check("lock_s3", lsrc[3], 3);
    check("lock_s4", lsrc[4], 0);
    auto = 1'b0;
    fifo_full = 1'b1;
    din[3*W +: W] = 37'h1234;
    req = 5'b01000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_wr", fifo_wrreq, 0);
      check("bp_ack", ack_out, 0);
    end
    fifo_full = 1'b0;
    tick();
    check("bp_rel_wr", fifo_wrreq, 1);
    check("bp_rel_src", fifo_src, 3);
    check("bp_rel_data", fifo_data, 37'h1234);
    check("bp_rel_ack", ack_out, 5'b01000);
    req = '0;
    tick();
    tick();
    check("bp_done_ack", ack_out, 0);
    din[1*W +: W] = 37'h0;
    req = 5'b00010;
    tick();
    check("hold_ack", ack_out, 5'b00010);
    check("hold_wr", fifo_wrreq, 1);
    #2 reset = 1'b1;
    #1;
    check("async_ack", ack_out, 0);
    check("async_wr", fifo_wrreq, 0);
    check("async_data", fifo_data, 0);
    req = '0;
    tick();
    reset = 1'b0;
    auto = 1'b1;
    nlog = 0;
    for (int c = 0; c < N; c++) begin
      fl[c][0] = 37'h10 | (37'(c) << 8);
      nf[c] = (c == 0 || c == 1 || c == 4) ? 1 : 0;
      pos[c] = 0;
    end
    run(15);
    check("post_rst_n", nlog, 3);
`ifdef NOC_ARB_LOCAL_PRIO_EN
    check("post_rst_s0", lsrc[0], 4);
    check("post_rst_s1", lsrc[1], 0);
    check("post_rst_s2", lsrc[2], 1);
`else
    check("post_rst_s0", lsrc[0], 0);
    check("post_rst_s1", lsrc[1], 1);
    check("post_rst_s2", lsrc[2], 4);
`endif
    do_reset();
    auto = 1'b1;
    fl[0][0] = 37'h10;
    nf[0] = 1;
    run(6);
    nlog = 0;
    fl[1][0] = 37'h110;
    fl[4][0] = 37'h410;
    nf[1] = 1;
    nf[4] = 1;
    run(10);
    check("prio_n", nlog, 2);
`ifdef NOC_ARB_LOCAL_PRIO_EN
    check("prio_first", lsrc[0], 4);
    check("prio_second", lsrc[1], 1);
`else
    check("prio_first", lsrc[0], 1);
    check("prio_second", lsrc[1], 4);
`endif
    check("prio_data", ldat[0], lsrc[0] == 4 ? 37'h410 : 37'h110);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
